// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential ALU core.
// Flag indices apply only when ALU_SEQ_FLAGS_EN is defined.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpMul = 3'b010,
    OpDiv = 3'b011,
    OpOr  = 3'b100,
    OpAnd = 3'b101,
    OpShl = 3'b110,
    OpShr = 3'b111
  } alu_op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StDiv  = 1'b1
  } alu_state_e;

  // Bit positions inside the {N, Z, C, V} flag vector.
  localparam int unsigned FlagV = 0;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagN = 3;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq_core.
// The flags signal exists only when ALU_SEQ_FLAGS_EN is defined.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             div_by_zero;
`ifdef ALU_SEQ_FLAGS_EN
  logic [3:0]       flags;
`endif

  modport master (
    output in_valid, op, a, b, out_ready,
`ifdef ALU_SEQ_FLAGS_EN
    input  flags,
`endif
    input  in_ready, out_valid, result, zero, div_by_zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
`ifdef ALU_SEQ_FLAGS_EN
    output flags,
`endif
    output in_ready, out_valid, result, zero, div_by_zero
  );

endinterface

// File: rtl/alu_div_iter.sv
// Restoring unsigned divider: one quotient bit per cycle, WIDTH cycles per division.
// stall freezes the last iteration until the consumer can take the quotient.
module alu_div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;

  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic             fits, last;

  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    fits    = ~diff[WIDTH];
    rem_nxt = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], fits};
    last    = (cnt_q == CntW'(WIDTH - 1));
  end

  assign busy     = busy_q;
  assign done     = busy_q & last & ~stall;
  // Final quotient is presented combinationally during the last iteration.
  assign quotient = quo_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q && !(last && stall)) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Registered ALU with valid/ready ports; div is iterative, every other op is single-cycle.
// Define ALU_SEQ_FLAGS_EN to add the registered {N, Z, C, V} flags output.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);

  alu_state_e       state_q, state_d;
  alu_op_e          op;
  logic [WIDTH-1:0] a, b;

  logic [WIDTH-1:0] result_q, alu_res, div_quo;
  logic             out_valid_q, zero_q, dbz_q, dbz_res;
  logic             in_ready, accept, div_start, div_busy, div_done, div_stall;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;

  assign op   = alu_op_e'(bus.op);
  assign a    = bus.a;
  assign b    = bus.b;
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = a - b;

  assign accept    = bus.in_valid & in_ready;
  assign div_start = accept & (op == OpDiv) & (b != '0);
  assign div_stall = out_valid_q & ~bus.out_ready;

  always_comb begin
    alu_res = '0;
    dbz_res = 1'b0;
    unique case (op)
      OpAdd: alu_res = sum[WIDTH-1:0];
      OpSub: alu_res = diff;
      OpMul: alu_res = a * b;
      // Only reaches the output register when b == 0.
      OpDiv: begin
        alu_res = '1;
        dbz_res = 1'b1;
      end
      OpOr:  alu_res = a | b;
      OpAnd: alu_res = a & b;
      OpShl: alu_res = a << b[SHAMT_W-1:0];
      OpShr: alu_res = a >> b[SHAMT_W-1:0];
    endcase
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic [3:0] flags_q, alu_flags, div_flags;

  always_comb begin
    alu_flags        = '0;
    alu_flags[FlagN] = alu_res[WIDTH-1];
    alu_flags[FlagZ] = (alu_res == '0);
    if (op == OpAdd) begin
      alu_flags[FlagC] = sum[WIDTH];
      alu_flags[FlagV] = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end else if (op == OpSub) begin
      alu_flags[FlagC] = (a >= b);
      alu_flags[FlagV] = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    end
    div_flags        = '0;
    div_flags[FlagN] = div_quo[WIDTH-1];
    div_flags[FlagZ] = (div_quo == '0);
  end

  assign bus.flags = flags_q;
`endif

  alu_div_iter #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (a),
    .divisor  (b),
    .stall    (div_stall),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (div_start) state_d = StDiv;
      StDiv:  if (div_done)  state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state_q == StIdle) && !div_busy && (!out_valid_q || bus.out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      flags_q     <= '0;
`endif
    end else if (accept && !div_start) begin
      result_q    <= alu_res;
      zero_q      <= (alu_res == '0);
      dbz_q       <= dbz_res;
      out_valid_q <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
      flags_q     <= alu_flags;
`endif
    end else if (div_done) begin
      result_q    <= div_quo;
      zero_q      <= (div_quo == '0);
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
      flags_q     <= div_flags;
`endif
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed self-checking bench for alu_seq_core at WIDTH=32.
module tb_alu_seq_core;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq_core #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op = 3'b000; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    step(); step();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.result !== 32'h0) begin fails++; $display("FAIL rst_result got %h want 0", bus.result); end
    tests++; if (bus.zero !== 1'b0) begin fails++; $display("FAIL rst_zero got %b want 0", bus.zero); end
    tests++; if (bus.div_by_zero !== 1'b0) begin fails++; $display("FAIL rst_dbz got %b want 0", bus.div_by_zero); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
`ifdef ALU_SEQ_FLAGS_EN
    tests++; if (bus.flags !== 4'b0000) begin fails++; $display("FAIL rst_flags got %b want 0000", bus.flags); end
`endif
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add_wrap();
    drive(3'b000, 32'hFFFF_FFFF, 32'h1);
    step();
    bus.in_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL add_valid got %b want 1", bus.out_valid); end
    tests++; if (bus.result !== 32'h0) begin fails++; $display("FAIL add_result got %h want 0", bus.result); end
    tests++; if (bus.zero !== 1'b1) begin fails++; $display("FAIL add_zero got %b want 1", bus.zero); end
    tests++; if (bus.div_by_zero !== 1'b0) begin fails++; $display("FAIL add_dbz got %b want 0", bus.div_by_zero); end
`ifdef ALU_SEQ_FLAGS_EN
    tests++; if (bus.flags !== 4'b0110) begin fails++; $display("FAIL add_flags got %b want 0110", bus.flags); end
`endif
    step();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL add_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    drive(3'b001, 32'd10, 32'd3);
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready0 got %b want 1", bus.in_ready); end
    step();
    tests++; if (bus.result !== 32'd7 || bus.zero !== 1'b0) begin
      fails++; $display("FAIL b2b_sub got %h/%b want 7/0", bus.result, bus.zero); end
`ifdef ALU_SEQ_FLAGS_EN
    tests++; if (bus.flags !== 4'b0010) begin fails++; $display("FAIL b2b_sub_flags got %b want 0010", bus.flags); end
`endif
    drive(3'b010, 32'h0001_0000, 32'h0001_0000);
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready1 got %b want 1", bus.in_ready); end
    step();
    tests++; if (bus.result !== 32'h0 || bus.zero !== 1'b1) begin
      fails++; $display("FAIL b2b_mul got %h/%b want 0/1", bus.result, bus.zero); end
    drive(3'b110, 32'h1, 32'd31);
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready2 got %b want 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    tests++; if (bus.result !== 32'h8000_0000 || bus.out_valid !== 1'b1) begin
      fails++; $display("FAIL b2b_shl got %h/%b want 80000000/1", bus.result, bus.out_valid); end
    step();
  endtask

  task automatic test_misc_ops();
    logic [2:0]  ops [6];
    logic [31:0] av  [6];
    logic [31:0] bv  [6];
    logic [31:0] ev  [6];
    logic [3:0]  fv  [6];
    ops = '{3'b001, 3'b010, 3'b111, 3'b110, 3'b101, 3'b000};
    av  = '{32'd3, 32'd3, 32'h8000_0000, 32'h1, 32'hF0F0, 32'h7FFF_FFFF};
    bv  = '{32'd10, 32'd5, 32'd4, 32'h24, 32'hFF00, 32'h1};
    ev  = '{32'hFFFF_FFF9, 32'd15, 32'h0800_0000, 32'h10, 32'hF000, 32'h8000_0000};
    fv  = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1001};
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], av[i], bv[i]);
      step();
      tests++; if (bus.result !== ev[i] || bus.out_valid !== 1'b1) begin
        fails++; $display("FAIL misc_%0d got %h/%b want %h/1", i, bus.result, bus.out_valid, ev[i]); end
`ifdef ALU_SEQ_FLAGS_EN
      tests++; if (bus.flags !== fv[i]) begin
        fails++; $display("FAIL misc_flags_%0d got %b want %b", i, bus.flags, fv[i]); end
`else
      if (fv[i] === 4'bxxxx) $display("unexpected flag vector");
`endif
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_div();
    int busy_bad;
    busy_bad = 0;
    drive(3'b011, 32'd100, 32'd7);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) busy_bad++;
      step();
    end
    tests++; if (busy_bad !== 0) begin
      fails++; $display("FAIL div_busy got %0d bad cycles want 0", busy_bad); end
    tests++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd14) begin
      fails++; $display("FAIL div_result got %h/%b want 0000000e/1", bus.result, bus.out_valid); end
    tests++; if (bus.div_by_zero !== 1'b0) begin fails++; $display("FAIL div_dbz got %b want 0", bus.div_by_zero); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL div_ready got %b want 1", bus.in_ready); end
    step();
  endtask

  task automatic test_div_zero();
    drive(3'b011, 32'd5, 32'd0);
    step();
    tests++; if (bus.result !== 32'hFFFF_FFFF || bus.div_by_zero !== 1'b1 || bus.out_valid !== 1'b1) begin
      fails++; $display("FAIL dbz_result got %h/%b want ffffffff/1", bus.result, bus.div_by_zero); end
    drive(3'b101, 32'hFF, 32'h0F);
    step();
    bus.in_valid = 1'b0;
    tests++; if (bus.result !== 32'h0F || bus.div_by_zero !== 1'b0) begin
      fails++; $display("FAIL dbz_clear got %h/%b want 0000000f/0", bus.result, bus.div_by_zero); end
    step();
  endtask

  task automatic test_hold();
    int hold_bad;
    hold_bad = 0;
    bus.out_ready = 1'b0;
    drive(3'b100, 32'hF0, 32'h0F);
    step();
    drive(3'b000, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) begin
      if (bus.result !== 32'hFF || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) hold_bad++;
      step();
    end
    tests++; if (hold_bad !== 0) begin fails++; $display("FAIL hold_stable got %0d bad cycles want 0", hold_bad); end
    bus.out_ready = 1'b1;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL hold_release got %b want 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    tests++; if (bus.result !== 32'd7 || bus.out_valid !== 1'b1) begin
      fails++; $display("FAIL hold_next got %h/%b want 00000007/1", bus.result, bus.out_valid); end
    step();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL hold_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_div();
    int late;
    late = 0;
    drive(3'b011, 32'd1000, 32'd3);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL rdiv_abort got %b/%b want 0/1", bus.out_valid, bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    drive(3'b000, 32'd2, 32'd2);
    step();
    bus.in_valid = 1'b0;
    tests++; if (bus.result !== 32'd4 || bus.out_valid !== 1'b1) begin
      fails++; $display("FAIL rdiv_add got %h/%b want 00000004/1", bus.result, bus.out_valid); end
    step();
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid !== 1'b0) late++;
      step();
    end
    tests++; if (late !== 0) begin fails++; $display("FAIL rdiv_late got %0d valid cycles want 0", late); end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_back_to_back();
    test_misc_ops();
    test_div();
    test_div_zero();
    test_hold();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Parametrised, registered successor to the processor's combinational ALU result mux.
- Same 3-bit op encoding (add, sub, mul, div, or, and, shl, shr); width is configurable.
- Operands arrive on a valid/ready input port; one registered result leaves on a valid/ready output port.
- Division is iterative (one quotient bit per cycle), so execute can stall on div and stream all other ops at one per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4, power of two).
- SHAMT_W, $clog2(WIDTH), shift-amount bits taken from b.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand handshake valid
- in_ready  out  1  core can accept op/operands this cycle
- op  in  3  000 add, 001 sub, 010 mul, 011 div, 100 or, 101 and, 110 shl, 111 shr
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- div_by_zero  out  1  result came from div with b == 0

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE; out_valid = 0; result = 0; zero = 0; div_by_zero = 0; divider registers cleared.
  - Any in-flight division is aborted and its result is lost.
- Accept condition: in_valid && in_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready). A result can be consumed and a new op accepted in the same cycle.
- Arithmetic:
  - All unsigned, modulo 2^WIDTH.
  - add/sub wrap.
  - mul returns the low WIDTH bits of the product.
  - shl/shr are logical, shift amount = b[SHAMT_W-1:0].
  - div returns the unsigned quotient a / b.
- Non-div op accepted at edge N: result, zero and out_valid = 1 registered at edge N (visible cycle N+1). Latency is 1 and throughput is 1 per cycle.
- div with b != 0:
  - IDLE → DIV on accept; restoring divider loads a/b.
  - DIV runs exactly WIDTH cycles.
  - On the final iteration: quotient → result, out_valid = 1, state → IDLE.
  - Latency WIDTH+1 cycles from accept to out_valid.
  - in_ready = 0 throughout DIV.
- div with b == 0: completes like a non-div op (latency 1); result = all ones, div_by_zero = 1.
- div_by_zero is 0 for every other result.
- Output hold: while out_valid && !out_ready, result and flags stay stable. No new op is accepted (in_ready = 0), and a finishing division holds in DIV on its last iteration until the output slot frees.
- out_valid clears on out_ready when no new result is written the same cycle.
- in_valid while in_ready = 0: ignored; the upstream must hold its inputs.
- Illegal ops: none; all 8 encodings are defined.

Optional Feature:
- Macro ALU_SEQ_FLAGS_EN.
- Defined: adds output port flags[3:0] = {N, Z, C, V}, registered with result.
  - N = result[WIDTH-1]; Z = zero.
  - C = carry-out for add, no-borrow (a ≥ b) for sub, else 0.
  - V = signed overflow for add/sub, else 0.
  - flags reset to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_seq_pkg:
  - alu_op_e enum (ADD, SUB, MUL, DIV, OR, AND, SHL, SHR, 3-bit);
  - state enum (IDLE, DIV);
  - flag bit-index constants.
- One sub-module alu_div_iter, the WIDTH-cycle restoring unsigned divider:
  - start/busy/done handshake;
  - quotient output;
  - stall input for the held last iteration.
- Top holds the op decode, the single-cycle datapath and the output register.

Test Plan (WIDTH=32):
- add a=0xFFFFFFFF, b=1, out_ready=1 → next cycle result=0, zero=1, out_valid=1 (flags C=1, Z=1 with macro).
- Back-to-back sub 10-3, mul 0x10000·0x10000, shl 1<<31 on consecutive cycles → results 7, 0 (zero=1), 0x80000000 on three consecutive cycles; in_ready stays 1.
- div 100/7 → in_ready low 32 cycles; result=14 exactly 33 cycles after accept; div_by_zero=0.
- div 5/0 → next cycle result=0xFFFFFFFF, div_by_zero=1.
- Hold out_ready=0 for 5 cycles after an or 0xF0|0x0F → result 0xFF stable, in_ready=0; release → one transfer, then new op accepted same cycle.
- Assert rst_n low at DIV cycle 10 → out_valid=0, state IDLE, in_ready=1 after release; next add 2+2 → 4.
